// File: rtl/crc_arb_pkg.sv
// Shared constants for the CRC job arbiter: engine register map, CTRL bit
// positions and FSM state encodings.
package crc_arb_pkg;

  // CRC engine register map
  localparam logic [31:0] CRC_DATA_A  = 32'h4003_2000;
  localparam logic [31:0] CRC_GPOLY_A = 32'h4003_2004;
  localparam logic [31:0] CRC_CTRL_A  = 32'h4003_2008;

  // CTRL register fields
  localparam int TOT_MSB  = 31;
  localparam int TOT_LSB  = 30;
  localparam int TOTR_MSB = 29;
  localparam int TOTR_LSB = 28;
  localparam int FXOR_BIT = 26;
  localparam int WAS_BIT  = 25;
  localparam int TCRC_BIT = 24;

  // FSM state encodings
  localparam int STW = 4;
  localparam logic [STW-1:0] IDLE    = 4'd0;
  localparam logic [STW-1:0] W_POLY  = 4'd1;
  localparam logic [STW-1:0] W_CSEED = 4'd2;
  localparam logic [STW-1:0] W_SEED  = 4'd3;
  localparam logic [STW-1:0] W_CDATA = 4'd4;
  localparam logic [STW-1:0] DATA    = 4'd5;
  localparam logic [STW-1:0] RD1     = 4'd6;
  localparam logic [STW-1:0] RD2     = 4'd7;
  localparam logic [STW-1:0] RESP    = 4'd8;

  // CTRL image with the write-as-seed bit forced to the given value
  function automatic logic [31:0] ctrl_with_was(input logic [31:0] ctrl, input logic was);
    logic [31:0] r;
    r = ctrl;
    r[WAS_BIT] = was;
    return r;
  endfunction

endpackage

// File: rtl/crc_rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after
// the pointer, wrapping modulo NREQ. The pointer itself lives in the parent.
module crc_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Scan priority positions ptr, ptr+1, ... and pick the first hit.
  // Request bits are indexed only by the loop constant i to keep indexing static.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any && req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          idx    = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/crc_job_arbiter.sv
// Bus-master front end that shares one CRC engine among NREQ requesters.
// Each granted job runs as an atomic register sequence (poly, seed load,
// data stream, double read of the result) and returns a tagged checksum.
module crc_job_arbiter
  import crc_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_poly,
  input  logic [32*NREQ-1:0]   req_ctrl,
  input  logic [32*NREQ-1:0]   req_seed,
  output logic [NREQ-1:0]      req_ack,
  input  logic [NREQ-1:0]      dat_valid,
  input  logic [32*NREQ-1:0]   dat_data,
  input  logic [NREQ-1:0]      dat_last,
  output logic [NREQ-1:0]      dat_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic [IDW-1:0]       res_id,
  output logic                 busy,
  output logic                 sel,
  output logic                 rw,
  output logic [31:0]          addr,
  output logic [31:0]          data_wr,
  input  logic [31:0]          data_rd
);

  logic [STW-1:0]  state_reg, state_next;
  logic [IDW-1:0]  ptr_reg, gnt_idx_reg;
  logic [NREQ-1:0] gnt_oh_reg, req_ack_reg;
  logic [31:0]     poly_reg, ctrl_reg, seed_reg, res_data_reg;
  logic [31:0]     addr_reg, wdata_reg;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;

  logic [31:0]     cand_poly, cand_ctrl, cand_seed, cur_data;
  logic            cur_valid, cur_last;

  logic            bus_sel, bus_rw;
  logic [31:0]     bus_addr, bus_wdata;

  crc_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Select the candidate descriptor and the granted requester's data lane
  always_comb begin
    cand_poly = '0;
    cand_ctrl = '0;
    cand_seed = '0;
    cur_data  = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        cand_poly = req_poly[32*i +: 32];
        cand_ctrl = req_ctrl[32*i +: 32];
        cand_seed = req_seed[32*i +: 32];
      end
      if (gnt_oh_reg[i]) begin
        cur_data  = dat_data[32*i +: 32];
        cur_valid = dat_valid[i];
        cur_last  = dat_last[i];
      end
    end
  end

  // Next state and the bus access issued in the current state
  always_comb begin
    state_next = state_reg;
    bus_sel    = 1'b0;
    bus_rw     = 1'b0;
    bus_addr   = addr_reg;
    bus_wdata  = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (arb_any) state_next = W_POLY;
      end
      W_POLY: begin
        bus_sel = 1'b1; bus_rw = 1'b1;
        bus_addr = CRC_GPOLY_A; bus_wdata = poly_reg;
        state_next = W_CSEED;
      end
      W_CSEED: begin
        bus_sel = 1'b1; bus_rw = 1'b1;
        bus_addr = CRC_CTRL_A; bus_wdata = ctrl_with_was(ctrl_reg, 1'b1);
        state_next = W_SEED;
      end
      W_SEED: begin
        bus_sel = 1'b1; bus_rw = 1'b1;
        bus_addr = CRC_DATA_A; bus_wdata = seed_reg;
        state_next = W_CDATA;
      end
      W_CDATA: begin
        bus_sel = 1'b1; bus_rw = 1'b1;
        bus_addr = CRC_CTRL_A; bus_wdata = ctrl_with_was(ctrl_reg, 1'b0);
        state_next = DATA;
      end
      DATA: begin
        if (cur_valid) begin
          bus_sel = 1'b1; bus_rw = 1'b1;
          bus_addr = CRC_DATA_A; bus_wdata = cur_data;
          if (cur_last) state_next = RD1;
        end
      end
      RD1: begin
        // First read only flushes the engine pipeline; its value is discarded
        bus_sel = 1'b1; bus_addr = CRC_DATA_A;
        state_next = RD2;
      end
      RD2: begin
        bus_sel = 1'b1; bus_addr = CRC_DATA_A;
        state_next = RESP;
      end
      RESP: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and last-issued address/write data (held while the bus is idle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (bus_sel) begin
        addr_reg  <= bus_addr;
        wdata_reg <= bus_wdata;
      end
    end
  end

  // Grant bookkeeping: descriptor latch, ack pulse, pointer advance, result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg      <= '0;
      gnt_idx_reg  <= '0;
      gnt_oh_reg   <= '0;
      req_ack_reg  <= '0;
      poly_reg     <= '0;
      ctrl_reg     <= '0;
      seed_reg     <= '0;
      res_data_reg <= '0;
    end else begin
      req_ack_reg <= '0;
      if (state_reg == IDLE && arb_any) begin
        poly_reg    <= cand_poly;
        ctrl_reg    <= cand_ctrl;
        seed_reg    <= cand_seed;
        gnt_oh_reg  <= arb_gnt;
        gnt_idx_reg <= arb_idx;
        req_ack_reg <= arb_gnt;
        ptr_reg     <= (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + IDW'(1);
      end
      if (state_reg == RD2) res_data_reg <= data_rd;
    end
  end

  assign sel       = bus_sel;
  assign rw        = bus_rw;
  assign addr      = bus_addr;
  assign data_wr   = bus_wdata;
  assign req_ack   = req_ack_reg;
  assign dat_ready = (state_reg == DATA) ? gnt_oh_reg : '0;
  assign res_valid = (state_reg == RESP);
  assign res_data  = res_data_reg;
  assign res_id    = gnt_idx_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_crc_job_arbiter.sv
// Directed bench for crc_job_arbiter with a simple CRC-bus model.
module tb_crc_job_arbiter;
  import crc_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 3;

  logic              clk, rst;
  logic [NREQ-1:0]   req_valid, req_ack, dat_valid, dat_last, dat_ready;
  logic [32*NREQ-1:0] req_poly, req_ctrl, req_seed, dat_data;
  logic              res_valid, res_ready, busy, sel, rw;
  logic [31:0]       res_data, addr, data_wr, data_rd, rd_val;
  logic [IDW-1:0]    res_id;

  int checks = 0;
  int errors = 0;

  logic [63:0] wq[$];
  int rd_cnt = 0;

  crc_job_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_poly(req_poly), .req_ctrl(req_ctrl),
    .req_seed(req_seed), .req_ack(req_ack),
    .dat_valid(dat_valid), .dat_data(dat_data), .dat_last(dat_last),
    .dat_ready(dat_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy),
    .sel(sel), .rw(rw), .addr(addr), .data_wr(data_wr), .data_rd(data_rd)
  );

  assign data_rd = rd_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: log every write and count reads at the sampling edge
  always @(posedge clk) begin
    if (sel && rw) wq.push_back({addr, data_wr});
    if (sel && !rw) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // which: 0 req_ack!=0, 1 res_valid, 2 dat_ready!=0, 3 busy==0
  task automatic wait_sig(input string tag, input int which, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
      case (which)
        0: hit = (req_ack != '0);
        1: hit = res_valid;
        2: hit = (dat_ready != '0);
        default: hit = !busy;
      endcase
    end
    checks++;
    assert (hit) else begin
      errors++;
      $error("FAIL %s: timeout observed 0 expected 1", tag);
    end
  endtask

  initial begin
    int n;
    int gq[$];
    bit dr0, dr1;
    logic [31:0] words [4];
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333; words[3] = 32'h4444_4444;

    rst = 1'b1; req_valid = '0; req_poly = '0; req_ctrl = '0; req_seed = '0;
    dat_valid = '0; dat_data = '0; dat_last = '0; res_ready = 1'b0;
    rd_val = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_sel", sel, 0);        chk("rst_rw", rw, 0);
    chk("rst_addr", addr, 0);      chk("rst_wdata", data_wr, 0);
    chk("rst_busy", busy, 0);      chk("rst_res_valid", res_valid, 0);
    chk("rst_dat_ready", dat_ready, 0); chk("rst_req_ack", req_ack, 0);
    rst = 1'b0;
    @(negedge clk);

    // Job 1: requester 0, single word
    req_poly[31:0] = 32'h0000_1021; req_ctrl[31:0] = 32'h0100_0000;
    req_seed[31:0] = 32'hFFFF_FFFF; dat_data[31:0] = 32'h1234_5678;
    dat_valid = 2'b01; dat_last = 2'b01;
    wq.delete(); rd_cnt = 0;
    req_valid = 2'b01;
    wait_sig("t1_ack_wait", 0, n);
    chk("t1_ack", req_ack, 2'b01);
    chk("t1_busy", busy, 1);
    req_valid = '0;
    wait_sig("t1_res_wait", 1, n);
    chk("t1_latency", n, 7);
    chk("t1_nwr", wq.size(), 5);
    chk("t1_wr0", wq[0], {CRC_GPOLY_A, 32'h0000_1021});
    chk("t1_wr1", wq[1], {CRC_CTRL_A, 32'h0300_0000});
    chk("t1_wr2", wq[2], {CRC_DATA_A, 32'hFFFF_FFFF});
    chk("t1_wr3", wq[3], {CRC_CTRL_A, 32'h0100_0000});
    chk("t1_wr4", wq[4], {CRC_DATA_A, 32'h1234_5678});
    chk("t1_nrd", rd_cnt, 2);
    chk("t1_res_data", res_data, 32'hCAFE_F00D);
    chk("t1_res_id", res_id, 0);
    $display("job id=%0d res=%h", res_id, res_data);
    res_ready = 1'b1;
    @(negedge clk);
    chk("t1_res_drop", res_valid, 0);
    chk("t1_idle", busy, 0);
    res_ready = 1'b0; dat_valid = '0; dat_last = '0;

    // Round robin with both requesting from reset
    rst = 1'b1; req_valid = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    dat_valid = 2'b11; dat_last = 2'b11; res_ready = 1'b1;
    dr0 = 1'b0; dr1 = 1'b0;
    for (int c = 0; c < 80 && gq.size() < 4; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        gq.push_back(req_ack[1] ? 1 : 0);
        $display("grant id=%0d", req_ack[1] ? 1 : 0);
      end
      if (gq.size() == 1) begin
        dr0 |= dat_ready[0];
        dr1 |= dat_ready[1];
      end
    end
    req_valid = '0;
    chk("rr_ngrants", gq.size(), 4);
    chk("rr_g0", gq[0], 0); chk("rr_g1", gq[1], 1);
    chk("rr_g2", gq[2], 0); chk("rr_g3", gq[3], 1);
    chk("rr_dr0_seen", dr0, 1);
    chk("rr_dr1_job0", dr1, 0);
    wait_sig("rr_drain", 3, n);
    res_ready = 1'b0; dat_valid = '0; dat_last = '0;

    // Job from requester 1: 4 words with a 3-cycle gap; requester 0 drives junk
    req_poly[63:32] = 32'hA5A5_0001; req_ctrl[63:32] = 32'h0100_0000;
    req_seed[63:32] = 32'h0000_0000;
    dat_valid[0] = 1'b1; dat_data[31:0] = 32'hDEAD_BEEF;
    rd_val = 32'h1357_9BDF;
    wq.delete(); rd_cnt = 0;
    @(negedge clk);
    req_valid = 2'b10;
    wait_sig("t3_ack_wait", 0, n);
    chk("t3_ack", req_ack, 2'b10);
    req_valid = '0;
    wait_sig("t3_data_wait", 2, n);
    chk("t3_dat_ready", dat_ready, 2'b10);
    for (int w = 0; w < 4; w++) begin
      if (w == 2) begin
        dat_valid[1] = 1'b0;
        for (int gcy = 0; gcy < 3; gcy++) begin
          #1;
          chk("t3_gap_sel", sel, 0);
          @(negedge clk);
        end
      end
      dat_valid[1] = 1'b1; dat_data[63:32] = words[w]; dat_last[1] = (w == 3);
      @(negedge clk);
    end
    dat_valid = '0; dat_last = '0;
    // Requester 0 asks while the result is pending; it must wait for the handshake
    req_poly[31:0] = 32'h04C1_1DB7; req_ctrl[31:0] = 32'h0100_0000; req_seed[31:0] = '0;
    req_valid = 2'b01;
    wait_sig("t3_res_wait", 1, n);
    chk("t3_nwr", wq.size(), 8);
    chk("t3_wr0", wq[0], {CRC_GPOLY_A, 32'hA5A5_0001});
    for (int w = 0; w < 4; w++) chk("t3_word", wq[4+w], {CRC_DATA_A, words[w]});
    chk("t3_nrd", rd_cnt, 2);
    for (int h = 0; h < 5; h++) begin
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_data", res_data, 32'h1357_9BDF);
      chk("t4_hold_id", res_id, 1);
      chk("t4_no_grant", req_ack, 0);
      @(negedge clk);
    end
    $display("job id=%0d res=%h", res_id, res_data);
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4_res_drop", res_valid, 0);
    chk("t4_ack_not_yet", req_ack, 0);
    res_ready = 1'b0;
    @(negedge clk);
    chk("t4_regrant", req_ack, 2'b01);
    req_valid = '0;

    // Reset during DATA of requester 0's job
    wait_sig("t5_data_wait", 2, n);
    chk("t5_in_data", dat_ready, 2'b01);
    rst = 1'b1;
    #1;
    chk("t5_sel", sel, 0);          chk("t5_rw", rw, 0);
    chk("t5_addr", addr, 0);        chk("t5_wdata", data_wr, 0);
    chk("t5_busy", busy, 0);        chk("t5_dat_ready", dat_ready, 0);
    chk("t5_res_valid", res_valid, 0); chk("t5_res_data", res_data, 0);
    chk("t5_req_ack", req_ack, 0);

    // Restart: pointer back at 0, ctrl with bit25 already set
    req_valid = 2'b11;
    req_poly[31:0] = 32'h1EDC_6F41; req_ctrl[31:0] = 32'h5600_0000;
    req_seed[31:0] = 32'h1111_0000; dat_data[31:0] = 32'hABCD_EF01;
    dat_valid = 2'b01; dat_last = 2'b01; rd_val = 32'h0F0F_0F0F;
    repeat (2) @(negedge clk);
    chk("t5_no_res", res_valid, 0);
    wq.delete(); rd_cnt = 0;
    rst = 1'b0;
    wait_sig("t6_ack_wait", 0, n);
    chk("t6_ack_ptr0", req_ack, 2'b01);
    req_valid = '0;
    wait_sig("t6_res_wait", 1, n);
    chk("t6_nwr", wq.size(), 5);
    chk("t6_wr0", wq[0], {CRC_GPOLY_A, 32'h1EDC_6F41});
    chk("t6_cseed", wq[1], {CRC_CTRL_A, 32'h5600_0000});
    chk("t6_seed", wq[2], {CRC_DATA_A, 32'h1111_0000});
    chk("t6_cdata", wq[3], {CRC_CTRL_A, 32'h5400_0000});
    chk("t6_word", wq[4], {CRC_DATA_A, 32'hABCD_EF01});
    chk("t6_res_data", res_data, 32'h0F0F_0F0F);
    chk("t6_res_id", res_id, 0);
    $display("job id=%0d res=%h", res_id, res_data);
    res_ready = 1'b1;
    @(negedge clk);
    chk("t6_res_drop", res_valid, 0);
    res_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
